// File: rtl/rv_pkg.sv
// Shared types for the post-execute result pipeline.
package rv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int AW_DEF   = 5;

    // One in-flight result: we = data present, ld = load issued but data not yet back.
    typedef struct packed {
        logic                we;
        logic                ld;
        logic [AW_DEF-1:0]   a;
        logic [XLEN_DEF-1:0] d;
    } wb_ent_t;

    localparam wb_ent_t WB_ENT_NULL = '0;

endpackage

// File: rtl/u_wb_pipe_fwd_mux.sv
// One forwarding read port: priority scan over the result stages, youngest wins.
module u_fwd_mux
    import rv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = 3
) (
    input  wb_ent_t         ent [DEPTH],
    input  logic [AW-1:0]   rd_a,
    input  logic            rd_use,
    input  logic [XLEN-1:0] rf_o,
    output logic [XLEN-1:0] d,
    output logic            nodat
);

    logic            hit_we;
    logic            hit_ld;
    logic [XLEN-1:0] hit_d;

    // Walk oldest to youngest so a younger match overrides an older one.
    always_comb begin
        hit_we = 1'b0;
        hit_ld = 1'b0;
        hit_d  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((ent[i].we || ent[i].ld) && (ent[i].a == rd_a)) begin
                hit_we = ent[i].we;
                hit_ld = ent[i].ld;
                hit_d  = ent[i].d;
            end
        end
    end

    // x0 never forwards; a pending load leaves the regfile value and raises nodat.
    always_comb begin
        d     = rf_o;
        nodat = 1'b0;
        if (rd_a != '0) begin
            if (hit_we) begin
                d = hit_d;
            end else if (hit_ld) begin
                nodat = rd_use;
            end
        end
    end

endmodule

// File: rtl/u_wb_pipe.sv
// Post-execute result pipeline: EX/load results flow to the regfile write port,
// with operand forwarding from every in-flight stage.
module u_wb_pipe
    import rv_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int AW       = AW_DEF,
    parameter int DEPTH    = 3,
    parameter int LD_STAGE = 2,
    parameter int NRD      = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_we,
    input  logic                ex_ld,
    input  logic [AW-1:0]       ex_rd_a,
    input  logic [XLEN-1:0]     ex_rd_d,
    input  logic [DEPTH-1:0]    stall,
    input  logic [DEPTH-1:0]    flush,
    input  logic                ld_vld,
    input  logic [XLEN-1:0]     ld_d,
    input  logic [NRD*AW-1:0]   rd_a,
    input  logic [NRD-1:0]      rd_use,
    input  logic [NRD*XLEN-1:0] rf_o,
    output logic [NRD*XLEN-1:0] fwd_d,
    output logic [NRD-1:0]      fwd_nodat,
    output logic                ld_wait,
    output logic                ld_pend,
    output logic                rf_we,
    output logic [AW-1:0]       rf_wa,
    output logic [XLEN-1:0]     rf_wd
);

    wb_ent_t stg     [DEPTH];
    wb_ent_t stg_nxt [DEPTH];
    wb_ent_t src     [DEPTH];
    wb_ent_t merged;
    wb_ent_t last;

    // View of the load stage with returning data folded in; used both when it holds and when it moves on.
    always_comb begin
        merged = stg[LD_STAGE];
        if (stg[LD_STAGE].ld && ld_vld) begin
            merged.we = 1'b1;
            merged.ld = 1'b0;
            merged.d  = ld_d;
        end
    end

    // What each stage would take if it advanced; x0 destinations are dropped at entry.
    always_comb begin
        src[0]    = WB_ENT_NULL;
        src[0].we = ex_we && (ex_rd_a != '0);
        src[0].ld = ex_ld && (ex_rd_a != '0);
        src[0].a  = ex_rd_a;
        src[0].d  = ex_rd_d;
        for (int i = 1; i < DEPTH; i++) begin
            src[i] = (i - 1 == LD_STAGE) ? merged : stg[i - 1];
        end
    end

    // Per-stage advance / bubble / hold, then flush clears the valid bits last.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stg_nxt[i] = stg[i];
            if (!stall[i]) begin
                if (i > 0 && stall[i - 1]) begin
                    stg_nxt[i] = WB_ENT_NULL;
                end else begin
                    stg_nxt[i] = src[i];
                end
            end else if (i == LD_STAGE) begin
                stg_nxt[i] = merged;
            end
            if (flush[i]) begin
                stg_nxt[i].we = 1'b0;
                stg_nxt[i].ld = 1'b0;
            end
        end
    end

    // Stage array register; reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg[i] <= WB_ENT_NULL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stg[i] <= stg_nxt[i];
            end
        end
    end

    // When loads merge in the last stage, returning data retires the same cycle.
    assign last  = (LD_STAGE == DEPTH - 1) ? merged : stg[DEPTH - 1];
    assign rf_we = last.we && !stall[DEPTH - 1];
    assign rf_wa = last.a;
    assign rf_wd = last.d;

    assign ld_wait = stg[LD_STAGE].ld && !ld_vld;

    // Any pending load anywhere in the pipe.
    always_comb begin
        ld_pend = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ld_pend = ld_pend | stg[i].ld;
        end
    end

    genvar p;
    generate
        for (p = 0; p < NRD; p++) begin : g_rd
            u_fwd_mux #(
                .XLEN  (XLEN),
                .AW    (AW),
                .DEPTH (DEPTH)
            ) u_mux (
                .ent    (stg),
                .rd_a   (rd_a[p*AW +: AW]),
                .rd_use (rd_use[p]),
                .rf_o   (rf_o[p*XLEN +: XLEN]),
                .d      (fwd_d[p*XLEN +: XLEN]),
                .nodat  (fwd_nodat[p])
            );
        end
    endgenerate

endmodule
